// File: rtl/cpu_cmd_sequencer.sv
// rtl/cpu_cmd_sequencer.sv - command queue and control sequencer for the cpu register-file datapath
// Queues LOAD/ADD/SUB/READ commands and drives the datapath pins with fixed hold times.
module cpu_cmd_sequencer #(
  parameter int DEPTH   = 4,
  parameter int ALU_CYC = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic [1:0]  cmd_op,
  input  logic [4:0]  cmd_ra,
  input  logic [4:0]  cmd_rb,
  input  logic [31:0] cmd_imm,
  input  logic        flush,
  output logic [4:0]  addressA,
  output logic [4:0]  addressB,
  output logic [31:0] dataIn,
  output logic [1:0]  opsel,
  output logic [1:0]  outsel,
  output logic        asel,
  output logic        bsel,
  output logic        oen,
  input  logic [31:0] dp_out,
  input  logic        dp_over,
  output logic        rsp_valid,
  output logic [31:0] rsp_data,
  output logic        rsp_ovf,
  output logic        ovf_sticky,
  input  logic        ovf_clr,
  output logic        busy
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = (ALU_CYC > 1) ? $clog2(ALU_CYC) : 1;
  localparam logic [1:0] OP_LOAD = 2'b00;
  localparam logic [1:0] OP_ADD  = 2'b01;
  localparam logic [1:0] OP_SUB  = 2'b10;
  localparam logic [1:0] OP_READ = 2'b11;

  typedef enum logic {IDLE, EXEC} state_t;
  state_t state, state_next;

  // Entry layout: {op[43:42], ra[41:37], rb[36:32], imm[31:0]}
  logic [43:0]   mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [AW:0]   count, count_next;
  logic          push, pop;
  logic [43:0]   head;

  logic [1:0]    cur_op, cur_op_next;
  logic [CW-1:0] cnt, cnt_next;
  logic [4:0]    addr_a_next, addr_b_next;
  logic [31:0]   data_in_next, rsp_data_next;
  logic [1:0]    opsel_next, outsel_next;
  logic          asel_next, bsel_next, oen_next;
  logic          rsp_valid_next, rsp_ovf_next, sticky_next;

  assign push = cmd_valid && cmd_ready && !flush;
  assign pop  = (state == IDLE) && (count != '0) && !flush;
  assign head = mem[rd_ptr];
  assign busy = (state == EXEC) || (count != '0);

  always_comb begin
    count_next = count;
    if (flush) begin
      count_next = '0;
    end else if (push && !pop) begin
      count_next = count + 1'b1;
    end else if (pop && !push) begin
      count_next = count - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= {cmd_op, cmd_ra, cmd_rb, cmd_imm};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
      cmd_ready <= 1'b1;
    end else begin
      if (flush) begin
        wr_ptr <= '0;
        rd_ptr <= '0;
      end else begin
        if (push) wr_ptr <= wr_ptr + AW'(1);
        if (pop)  rd_ptr <= rd_ptr + AW'(1);
      end
      count     <= count_next;
      cmd_ready <= (count_next != (AW+1)'(DEPTH));
    end
  end

  always_comb begin
    state_next     = state;
    cur_op_next    = cur_op;
    cnt_next       = cnt;
    addr_a_next    = addressA;
    addr_b_next    = addressB;
    data_in_next   = dataIn;
    opsel_next     = opsel;
    outsel_next    = outsel;
    asel_next      = asel;
    bsel_next      = bsel;
    oen_next       = oen;
    rsp_valid_next = 1'b0;
    rsp_data_next  = rsp_data;
    rsp_ovf_next   = rsp_ovf;
    sticky_next    = ovf_clr ? 1'b0 : ovf_sticky;
    case (state)
      IDLE: begin
        if (pop) begin
          state_next   = EXEC;
          cur_op_next  = head[43:42];
          cnt_next     = (head[43:42] == OP_ADD || head[43:42] == OP_SUB) ? CW'(ALU_CYC - 1) : '0;
          addr_a_next  = head[41:37];
          addr_b_next  = head[36:32];
          data_in_next = 32'd0;
          opsel_next   = 2'b01;
          outsel_next  = 2'b00;
          asel_next    = 1'b1;
          bsel_next    = 1'b0;
          oen_next     = 1'b1;
          case (head[43:42])
            OP_LOAD: begin
              addr_a_next  = 5'd0;
              data_in_next = head[31:0];
              asel_next    = 1'b0;
            end
            OP_ADD, OP_SUB: begin
              opsel_next  = (head[43:42] == OP_ADD) ? 2'b00 : 2'b01;
              outsel_next = 2'b01;
              bsel_next   = 1'b1;
            end
            default: addr_b_next = head[41:37];
          endcase
        end
      end
      EXEC: begin
        if (cnt == '0) begin
          state_next   = IDLE;
          addr_a_next  = 5'd0;
          addr_b_next  = 5'd0;
          data_in_next = 32'd0;
          opsel_next   = 2'b01;
          outsel_next  = 2'b00;
          asel_next    = 1'b1;
          bsel_next    = 1'b0;
          oen_next     = 1'b0;
          if (cur_op != OP_LOAD) begin
            rsp_valid_next = 1'b1;
            rsp_data_next  = dp_out;
            rsp_ovf_next   = (cur_op != OP_READ) && dp_over;
          end
          // Set beats a same-cycle clear.
          if ((cur_op == OP_ADD || cur_op == OP_SUB) && dp_over) sticky_next = 1'b1;
        end else begin
          cnt_next = cnt - 1'b1;
        end
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      cur_op     <= OP_LOAD;
      cnt        <= '0;
      addressA   <= 5'd0;
      addressB   <= 5'd0;
      dataIn     <= 32'd0;
      opsel      <= 2'b01;
      outsel     <= 2'b00;
      asel       <= 1'b1;
      bsel       <= 1'b0;
      oen        <= 1'b0;
      rsp_valid  <= 1'b0;
      rsp_data   <= 32'd0;
      rsp_ovf    <= 1'b0;
      ovf_sticky <= 1'b0;
    end else begin
      state      <= state_next;
      cur_op     <= cur_op_next;
      cnt        <= cnt_next;
      addressA   <= addr_a_next;
      addressB   <= addr_b_next;
      dataIn     <= data_in_next;
      opsel      <= opsel_next;
      outsel     <= outsel_next;
      asel       <= asel_next;
      bsel       <= bsel_next;
      oen        <= oen_next;
      rsp_valid  <= rsp_valid_next;
      rsp_data   <= rsp_data_next;
      rsp_ovf    <= rsp_ovf_next;
      ovf_sticky <= sticky_next;
    end
  end
endmodule
